// File: rtl/c_lfsr_ctrl.sv
// ---------------------------------------------------------------------------
// c_lfsr_ctrl
//   Sequencer and sharer for a single LFSR. Seeds the register, advances it
//   only when a word is handed out, and round-robin grants each fresh word to
//   one of num_ports requesters. A step counter flags when the sequence wraps.
//
//   The LFSR (Fibonacci, shift-left) and its feedback tap table are built in
//   here so the block is self-contained. index == 0 selects the base maximal
//   polynomial for the width; any other value selects its reciprocal (also
//   maximal). Widths above 32 fall back to a two-tap polynomial that is not
//   guaranteed maximal.
//
// Parameters
//   width      LFSR state width, >= 2
//   index      feedback polynomial select (0 base, else reciprocal)
//   complete   1: de Bruijn (period 2^width), 0: maximal (2^width-1)
//   num_ports  number of requesters, >= 1
//
// Ports
//   i_clk          clock, rising edge
//   i_reset        asynchronous reset, active low
//   i_seed_load    pulse: capture i_seed and (re)load the LFSR
//   i_seed         seed value, sampled with i_seed_load
//   i_enable       0: no grants, LFSR holds
//   i_req          per-port request for one word
//   o_gnt          one-hot grant (combinational)
//   o_rand_data    word delivered to the granted port, 0 when no grant
//   o_period_done  1-cycle pulse after the step counter wraps
//   o_seed_err     1-cycle pulse: zero seed in maximal mode replaced by ones
//   o_busy         1 while in LOAD
//
// Build option
//   C_LFSR_CTRL_AUTORESEED_EN : on period wrap, go through LOAD again with
//   the stored seed rotated left by one (one bubble cycle).
// ---------------------------------------------------------------------------
module c_lfsr_ctrl #(
    parameter int width     = 16,
    parameter int index     = 0,
    parameter int complete  = 0,
    parameter int num_ports = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_seed_load,
    input  logic [width-1:0]     i_seed,
    input  logic                 i_enable,
    input  logic [num_ports-1:0] i_req,
    output logic [num_ports-1:0] o_gnt,
    output logic [width-1:0]     o_rand_data,
    output logic                 o_period_done,
    output logic                 o_seed_err,
    output logic                 o_busy
);

    localparam int PW = (num_ports > 1) ? $clog2(num_ports) : 1;
    localparam int CW = width + 1;

    // Maximal-length tap masks (bit t-1 set for tap t), widths 2..32.
    function automatic logic [width-1:0] f_taps();
        logic [31:0]      t;
        logic [width-1:0] m;
        logic [width-1:0] r;
        case (width)
            2:  t = 32'h0000_0003;
            3:  t = 32'h0000_0006;
            4:  t = 32'h0000_000C;
            5:  t = 32'h0000_0014;
            6:  t = 32'h0000_0030;
            7:  t = 32'h0000_0060;
            8:  t = 32'h0000_00B8;
            9:  t = 32'h0000_0110;
            10: t = 32'h0000_0240;
            11: t = 32'h0000_0500;
            12: t = 32'h0000_0829;
            13: t = 32'h0000_100D;
            14: t = 32'h0000_2015;
            15: t = 32'h0000_6000;
            16: t = 32'h0000_D008;
            17: t = 32'h0001_2000;
            18: t = 32'h0002_0400;
            19: t = 32'h0004_0023;
            20: t = 32'h0009_0000;
            21: t = 32'h0014_0000;
            22: t = 32'h0030_0000;
            23: t = 32'h0042_0000;
            24: t = 32'h00E1_0000;
            25: t = 32'h0120_0000;
            26: t = 32'h0200_0023;
            27: t = 32'h0400_0013;
            28: t = 32'h0900_0000;
            29: t = 32'h1400_0000;
            30: t = 32'h2000_0029;
            31: t = 32'h4800_0000;
            32: t = 32'h8020_0003;
            default: t = 32'h0;
        endcase
        m = '0;
        if (width <= 32) begin
            for (int b = 0; b < width && b < 32; b++) m[b] = t[b];
        end else begin
            m[width-1] = 1'b1;
            m[width-2] = 1'b1;
        end
        if (index == 0) return m;
        // Reciprocal polynomial: tap t moves to width-t, top tap stays.
        r = '0;
        r[width-1] = 1'b1;
        for (int b = 0; b < width - 1; b++) if (m[b]) r[width-2-b] = 1'b1;
        return r;
    endfunction

    localparam logic [width-1:0] TAPS   = f_taps();
    localparam logic [width-1:0] ONES   = '1;
    localparam logic [CW-1:0]    P_LAST = (complete != 0) ? {1'b0, ONES}
                                                          : ({1'b0, ONES} - CW'(1));

    // A zero seed would lock a maximal-mode LFSR; substitute all-ones.
    function automatic logic [width-1:0] f_fix(input logic [width-1:0] v);
        return ((complete == 0) && (v == '0)) ? ONES : v;
    endfunction

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    state_t          r_state;
    logic [width-1:0] r_lfsr;
    logic [width-1:0] r_seed_q;
    logic [PW-1:0]    r_ptr;
    logic [CW-1:0]    r_step;
    logic             r_period_done;
    logic             r_seed_err;
    logic             r_busy;

    logic             w_fb;
    logic [width-1:0] w_lfsr_nxt;
    logic             w_can;
    logic             w_found;
    logic             w_grant;
    logic [PW-1:0]    w_gidx;
    logic [PW-1:0]    w_ptr_nxt;
    logic [num_ports-1:0] w_gnt;

    // De Bruijn mode splices the all-zero state in after the 100..0 state.
    assign w_fb       = (^(r_lfsr & TAPS)) ^ ((complete != 0) && (r_lfsr[width-2:0] == '0));
    assign w_lfsr_nxt = {r_lfsr[width-2:0], w_fb};

    // seed_load wins over any request in the same cycle.
    assign w_can   = (r_state == S_RUN) && i_enable && !i_seed_load;
    assign w_grant = w_can && w_found;

    // First requesting port at or after the pointer, searched cyclically.
    always_comb begin
        int j;
        w_found = 1'b0;
        w_gidx  = '0;
        j       = 0;
        for (int k = 0; k < num_ports; k++) begin
            j = int'(r_ptr) + k;
            if (j >= num_ports) j = j - num_ports;
            if (!w_found && i_req[j]) begin
                w_found = 1'b1;
                w_gidx  = PW'(j);
            end
        end
    end

    always_comb begin
        w_gnt = '0;
        if (w_grant) w_gnt[w_gidx] = 1'b1;
    end

    assign w_ptr_nxt = (w_gidx == PW'(num_ports - 1)) ? '0 : (w_gidx + PW'(1));

    assign o_gnt         = w_gnt;
    assign o_rand_data   = w_grant ? r_lfsr : '0;
    assign o_period_done = r_period_done;
    assign o_seed_err    = r_seed_err;
    assign o_busy        = r_busy;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state       <= S_IDLE;
            r_lfsr        <= ONES;
            r_seed_q      <= ONES;
            r_ptr         <= '0;
            r_step        <= '0;
            r_period_done <= 1'b0;
            r_seed_err    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_period_done <= 1'b0;
            r_seed_err    <= 1'b0;
            if (i_seed_load) begin
                r_seed_q   <= f_fix(i_seed);
                r_seed_err <= (complete == 0) && (i_seed == '0);
            end
            case (r_state)
                S_IDLE: begin
                    if (i_seed_load) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_lfsr <= r_seed_q;
                    r_step <= '0;
                    // A new seed_load while loading keeps us here to pick it up.
                    if (!i_seed_load) begin
                        r_state <= S_RUN;
                        r_busy  <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (i_seed_load) begin
                        r_state <= S_LOAD;
                        r_busy  <= 1'b1;
                    end else if (w_grant) begin
                        r_lfsr <= w_lfsr_nxt;
                        r_ptr  <= w_ptr_nxt;
                        if (r_step == P_LAST) begin
                            r_step        <= '0;
                            r_period_done <= 1'b1;
`ifdef C_LFSR_CTRL_AUTORESEED_EN
                            r_state  <= S_LOAD;
                            r_busy   <= 1'b1;
                            r_seed_q <= f_fix({r_seed_q[width-2:0], r_seed_q[width-1]});
`else
                            r_state  <= S_RUN;
`endif
                        end else begin
                            r_step <= r_step + CW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_c_lfsr_ctrl.sv
// Bench for c_lfsr_ctrl at width=4, num_ports=4. Two instances: dut
// (maximal mode) and dutc (de Bruijn mode) with separate stimulus.
module tb_c_lfsr_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       seed_load, enable;
    logic [3:0] seed, req;
    logic [3:0] gnt, rdata;
    logic       pdone, serr, busy;

    logic       c_seed_load, c_enable;
    logic [3:0] c_seed, c_req;
    logic [3:0] c_gnt, c_rdata;
    logic       c_pdone, c_serr, c_busy;

    int n_total = 0;
    int n_bad   = 0;
    int li      = 0;

    typedef struct {
        logic [3:0] gnt;
        logic [3:0] data;
    } exp_t;
    exp_t q[$];
    exp_t qc[$];
    exp_t em, ecm;

    // x^4+x^3+1 walked by hand from 4'hF; de Bruijn adds 0 after 8.
    logic [3:0] SEQ [15] = '{4'hF, 4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9,
                             4'h3, 4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7};
    logic [3:0] DB  [16] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD,
                             4'hA, 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

    always #5 clk = ~clk;

    c_lfsr_ctrl #(.width(4), .index(0), .complete(0), .num_ports(4)) dut (
        .i_clk(clk), .i_reset(rst_n), .i_seed_load(seed_load), .i_seed(seed),
        .i_enable(enable), .i_req(req), .o_gnt(gnt), .o_rand_data(rdata),
        .o_period_done(pdone), .o_seed_err(serr), .o_busy(busy));

    c_lfsr_ctrl #(.width(4), .index(0), .complete(1), .num_ports(4)) dutc (
        .i_clk(clk), .i_reset(rst_n), .i_seed_load(c_seed_load), .i_seed(c_seed),
        .i_enable(c_enable), .i_req(c_req), .o_gnt(c_gnt), .o_rand_data(c_rdata),
        .o_period_done(c_pdone), .o_seed_err(c_serr), .o_busy(c_busy));

    // Scoreboards: an entry pushed for a cycle must match that cycle's grant.
    always @(negedge clk) begin
        if (q.size() != 0 || gnt !== 4'b0) begin
            n_total++;
            if (q.size() == 0) begin
                n_bad++;
                $display("FAIL grant_unexpected: gnt=%b data=%h", gnt, rdata);
            end else begin
                em = q.pop_front();
                if (gnt !== em.gnt || rdata !== em.data) begin
                    n_bad++;
                    $display("FAIL grant: got gnt=%b data=%h want gnt=%b data=%h",
                             gnt, rdata, em.gnt, em.data);
                end
            end
        end
        if (qc.size() != 0 || c_gnt !== 4'b0) begin
            n_total++;
            if (qc.size() == 0) begin
                n_bad++;
                $display("FAIL grant_c_unexpected: gnt=%b data=%h", c_gnt, c_rdata);
            end else begin
                ecm = qc.pop_front();
                if (c_gnt !== ecm.gnt || c_rdata !== ecm.data) begin
                    n_bad++;
                    $display("FAIL grant_c: got gnt=%b data=%h want gnt=%b data=%h",
                             c_gnt, c_rdata, ecm.gnt, ecm.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; seed_load = 0; seed = 0; enable = 0; req = 0;
        c_seed_load = 0; c_seed = 0; c_enable = 0; c_req = 0;
        tick(); tick();
        @(negedge clk);
        n_total++;
        if ({gnt, rdata, pdone, serr, busy} !== 11'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b want 0", {gnt, rdata, pdone, serr, busy});
        end
        tick();
        rst_n = 1'b1;
        enable = 1; req = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_total++;
            if (gnt !== 4'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_no_grant: gnt=%b busy=%b want 0000/0", gnt, busy);
            end
            tick();
        end
        req = 0;
    endtask

    task automatic test_sequence();
        logic [15:0] seen;
        seen = '0;
        seed_load = 1; seed = 4'hF;
        tick();
        seed_load = 0;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b1 || serr !== 1'b0) begin
            n_bad++;
            $display("FAIL load_busy: busy=%b serr=%b want 1/0", busy, serr);
        end
        tick();
        req = 4'b0001;
        for (int k = 0; k < 15; k++) begin
            q.push_back('{4'b0001, SEQ[k]});
            @(negedge clk);
            seen[rdata] = 1'b1;
            n_total++;
            if (pdone !== 1'b0) begin
                n_bad++;
                $display("FAIL pdone_early k=%0d: got %b want 0", k, pdone);
            end
            tick();
        end
        n_total++;
        if (seen !== 16'hFFFE) begin
            n_bad++;
            $display("FAIL distinct_words: got %h want fffe", seen);
        end
`ifdef C_LFSR_CTRL_AUTORESEED_EN
        @(negedge clk);
        n_total++;
        if (gnt !== 4'b0 || busy !== 1'b1 || pdone !== 1'b1) begin
            n_bad++;
            $display("FAIL wrap_bubble: gnt=%b busy=%b pdone=%b want 0000/1/1", gnt, busy, pdone);
        end
        tick();
        q.push_back('{4'b0001, 4'hF});
        @(negedge clk);
        tick();
`else
        q.push_back('{4'b0001, 4'hF});
        @(negedge clk);
        n_total++;
        if (pdone !== 1'b1) begin
            n_bad++;
            $display("FAIL pdone_wrap: got %b want 1", pdone);
        end
        tick();
`endif
        q.push_back('{4'b0001, SEQ[1]});
        @(negedge clk);
        n_total++;
        if (pdone !== 1'b0) begin
            n_bad++;
            $display("FAIL pdone_single: got %b want 0", pdone);
        end
        tick();
        req = 0;
        li = 2;
    endtask

    task automatic test_round_robin();
        logic [3:0] eg [5];
        eg = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        req = 4'b1000;                       // ptr 1 -> 0
        q.push_back('{4'b1000, SEQ[li]}); li = (li + 1) % 15;
        @(negedge clk); tick();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            q.push_back('{eg[k], SEQ[li]}); li = (li + 1) % 15;
            @(negedge clk); tick();
        end
        req = 4'b0010;                       // ptr 1 -> 2
        q.push_back('{4'b0010, SEQ[li]}); li = (li + 1) % 15;
        @(negedge clk); tick();
        req = 4'b1010;
        q.push_back('{4'b1000, SEQ[li]}); li = (li + 1) % 15;
        @(negedge clk); tick();
        q.push_back('{4'b0010, SEQ[li]}); li = (li + 1) % 15;
        @(negedge clk); tick();
        req = 0;
    endtask

    task automatic test_seed_zero();
        seed_load = 1; seed = 4'h0;
        tick();
        seed_load = 0;
        @(negedge clk);
        n_total++;
        if (serr !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL seed_err_pulse: serr=%b busy=%b want 1/1", serr, busy);
        end
        tick();
        req = 4'b0001;                       // ptr is 2; only port 0 asks
        for (int k = 0; k < 3; k++) begin
            q.push_back('{4'b0001, SEQ[k]});
            @(negedge clk);
            if (k == 0) begin
                n_total++;
                if (serr !== 1'b0) begin
                    n_bad++;
                    $display("FAIL seed_err_width: got %b want 0", serr);
                end
            end
            tick();
        end
        req = 0;
        li = 3;
        // de Bruijn instance: zero seed is legal
        c_seed_load = 1; c_seed = 4'h0; c_enable = 1;
        tick();
        c_seed_load = 0;
        @(negedge clk);
        n_total++;
        if (c_serr !== 1'b0 || c_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL c_seed_err: serr=%b busy=%b want 0/1", c_serr, c_busy);
        end
        tick();
        c_req = 4'b0001;
        for (int k = 0; k < 16; k++) begin
            qc.push_back('{4'b0001, DB[k]});
            @(negedge clk);
            n_total++;
            if (c_pdone !== 1'b0) begin
                n_bad++;
                $display("FAIL c_pdone_early k=%0d: got %b want 0", k, c_pdone);
            end
            tick();
        end
`ifdef C_LFSR_CTRL_AUTORESEED_EN
        @(negedge clk);
        n_total++;
        if (c_gnt !== 4'b0 || c_pdone !== 1'b1) begin
            n_bad++;
            $display("FAIL c_wrap: gnt=%b pdone=%b want 0000/1", c_gnt, c_pdone);
        end
        tick();
`else
        qc.push_back('{4'b0001, 4'h0});
        @(negedge clk);
        n_total++;
        if (c_pdone !== 1'b1) begin
            n_bad++;
            $display("FAIL c_pdone_wrap: got %b want 1", c_pdone);
        end
        tick();
`endif
        c_req = 0;
    endtask

    task automatic test_seed_override();
        enable = 1; req = 4'b1111; seed_load = 1; seed = 4'h9;
        @(negedge clk);
        n_total++;
        if (gnt !== 4'b0) begin
            n_bad++;
            $display("FAIL override_no_grant: got %b want 0000", gnt);
        end
        tick();
        seed_load = 0;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b1 || gnt !== 4'b0) begin
            n_bad++;
            $display("FAIL override_busy: busy=%b gnt=%b want 1/0000", busy, gnt);
        end
        tick();
        q.push_back('{4'b0010, 4'h9});        // ptr still 1
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL override_run: busy=%b want 0", busy);
        end
        tick();
        li = 8;
        req = 0;
    endtask

    task automatic test_enable();
        enable = 0; req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_total++;
            if (gnt !== 4'b0 || rdata !== 4'h0) begin
                n_bad++;
                $display("FAIL enable_off: gnt=%b data=%h want 0000/0", gnt, rdata);
            end
            tick();
        end
        enable = 1;
        q.push_back('{4'b0100, SEQ[li]}); li = (li + 1) % 15;
        @(negedge clk); tick();
        q.push_back('{4'b1000, SEQ[li]}); li = (li + 1) % 15;
        @(negedge clk); tick();
        req = 0;
    endtask

    task automatic test_async_reset();
        enable = 1; req = 4'b1111;            // ptr 0
        q.push_back('{4'b0001, SEQ[li]});
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_total++;
        if ({gnt, rdata, pdone, serr, busy} !== 11'b0) begin
            n_bad++;
            $display("FAIL async_reset: got %b want 0", {gnt, rdata, pdone, serr, busy});
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_total++;
            if (gnt !== 4'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL post_reset_idle: gnt=%b busy=%b want 0000/0", gnt, busy);
            end
            tick();
        end
        seed_load = 1; seed = 4'h1;
        tick();
        seed_load = 0;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset_load: busy=%b want 1", busy);
        end
        tick();
        req = 4'b0001;
        q.push_back('{4'b0001, 4'h1});
        li = 5;
        @(negedge clk); tick();
`ifdef C_LFSR_CTRL_AUTORESEED_EN
        for (int k = 0; k < 14; k++) begin
            q.push_back('{4'b0001, SEQ[li]}); li = (li + 1) % 15;
            @(negedge clk); tick();
        end
        @(negedge clk);
        n_total++;
        if (gnt !== 4'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reseed_bubble: gnt=%b busy=%b want 0000/1", gnt, busy);
        end
        tick();
        q.push_back('{4'b0001, 4'h2});        // rotl(4'h1)
        @(negedge clk); tick();
`endif
        req = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sequence();
        test_round_robin();
        test_seed_zero();
        test_seed_override();
        test_enable();
        test_async_reset();
        tick();
        n_total++;
        if (q.size() != 0 || qc.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: left=%0d/%0d want 0/0", q.size(), qc.size());
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
